alu32_bist: RTL



---
 rtl/alu32_pkg.sv | 69 ++++++
 rtl/alu32_bist_vectors.sv | 50 +++++
 rtl/alu32_bist.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu32_pkg.sv
// Shared ALU32 definitions: opcodes, LFSR polynomial, golden model and LFSR step.
package alu32_pkg;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b01110;
  localparam logic [4:0] OP_SLT  = 5'b01111;
  localparam logic [4:0] OP_NOR  = 5'b11000;
  localparam logic [4:0] OP_NAND = 5'b11001;

  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [7:0] NUM_DIRECTED = 8'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } bist_state_t;

  typedef struct packed {
    logic [31:0] s;
    logic        eq;
    logic        overflow;
  } alu_res_t;

  function automatic alu_res_t alu32_golden(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
    alu_res_t    r;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        sub_ovf;
    sum        = a + b;
    diff       = a - b;
    sub_ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
    r.s        = 32'h0;
    r.eq       = (a == b);
    r.overflow = 1'b0;
    case (op)
      OP_AND:  r.s = a & b;
      OP_OR:   r.s = a | b;
      OP_ADD: begin
        r.s        = sum;
        r.overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        r.s        = diff;
        r.overflow = sub_ovf;
      end
      OP_SLT: begin
        r.s        = {31'b0, ($signed(a) < $signed(b))};
        r.overflow = sub_ovf;
      end
      OP_NOR:  r.s = ~(a | b);
      OP_NAND: r.s = ~(a & b);
      default: r.s = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/alu32_bist_vectors.sv
// Combinational directed-vector ROM (indices 0..12) and the random-vector opcode table.
module alu32_bist_vectors
  import alu32_pkg::*;
(
  input  logic [7:0]  i_index,
  input  logic [2:0]  i_rand_sel,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [4:0]  o_op,
  output logic [4:0]  o_rand_op
);

  always_comb begin
    o_a  = 32'h0;
    o_b  = 32'h0;
    o_op = OP_AND;
    case (i_index)
      8'd0:  begin o_a = 32'd45;        o_b = 32'd21;        o_op = OP_AND;  end
      8'd1:  begin o_a = 32'd45;        o_b = 32'd21;        o_op = OP_OR;   end
      8'd2:  begin o_a = 32'd45;        o_b = 32'd21;        o_op = OP_ADD;  end
      8'd3:  begin o_a = 32'd45;        o_b = 32'd21;        o_op = OP_SUB;  end
      8'd4:  begin o_a = 32'd45;        o_b = 32'd21;        o_op = OP_SLT;  end
      8'd5:  begin o_a = 32'd21;        o_b = 32'd45;        o_op = OP_SLT;  end
      8'd6:  begin o_a = 32'd21;        o_b = 32'd45;        o_op = OP_NOR;  end
      8'd7:  begin o_a = 32'd21;        o_b = 32'd45;        o_op = OP_NAND; end
      8'd8:  begin o_a = 32'd45;        o_b = 32'd45;        o_op = OP_SUB;  end
      8'd9:  begin o_a = 32'h7FFF_FFFF; o_b = 32'h0000_0001; o_op = OP_ADD;  end
      8'd10: begin o_a = 32'h8000_0000; o_b = 32'hFFFF_FFFF; o_op = OP_ADD;  end
      8'd11: begin o_a = 32'h8000_0000; o_b = 32'h0000_0001; o_op = OP_SUB;  end
      8'd12: begin o_a = 32'h7FFF_FFFF; o_b = 32'hFFFF_FFFF; o_op = OP_SLT;  end
      default: begin o_a = 32'h0; o_b = 32'h0; o_op = OP_AND; end
    endcase
  end

  always_comb begin
    o_rand_op = OP_AND;
    case (i_rand_sel)
      3'd0:    o_rand_op = OP_AND;
      3'd1:    o_rand_op = OP_OR;
      3'd2:    o_rand_op = OP_ADD;
      3'd3:    o_rand_op = OP_SUB;
      3'd4:    o_rand_op = OP_SLT;
      3'd5:    o_rand_op = OP_NOR;
      3'd6:    o_rand_op = OP_NAND;
      3'd7:    o_rand_op = OP_SUB;
      default: o_rand_op = OP_AND;
    endcase
  end

endmodule

// File: rtl/alu32_bist.sv
// ALU32 built-in self-test controller: directed then LFSR vectors, checked against a golden model.
// Optional ALU32_BIST_ERRCOUNT_EN: run all vectors and report a saturating err_count.
module alu32_bist
  import alu32_pkg::*;
#(
  parameter int          NUM_RANDOM    = 64,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_index,
  output logic [31:0] fail_S,
`ifdef ALU32_BIST_ERRCOUNT_EN
  output logic [7:0]  err_count,
`endif
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_S,
  input  logic        alu_eq,
  input  logic        alu_overflow
);

  localparam logic [7:0] LAST_IDX   = 8'(12 + NUM_RANDOM);
  localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYCLES - 1);

  bist_state_t r_state;
  logic [7:0]  r_index;
  logic [3:0]  r_settle;
  logic [31:0] r_lfsr;
  logic        r_busy, r_done, r_pass;
  logic [7:0]  r_fail_index;
  logic [31:0] r_fail_s, r_alu_a, r_alu_b;
  logic [4:0]  r_alu_op;
`ifdef ALU32_BIST_ERRCOUNT_EN
  logic [7:0]  r_err_count;
`endif

  logic [31:0] w_step1, w_step2, w_rom_a, w_rom_b;
  logic [4:0]  w_rom_op, w_rand_op;
  alu_res_t    w_gold;
  logic        w_check_eq, w_mismatch;

  assign w_step1 = lfsr_step(r_lfsr);
  assign w_step2 = lfsr_step(w_step1);

  alu32_bist_vectors u_vectors (
    .i_index    (r_index),
    .i_rand_sel (w_step2[2:0]),
    .o_a        (w_rom_a),
    .o_b        (w_rom_b),
    .o_op       (w_rom_op),
    .o_rand_op  (w_rand_op)
  );

  // eq is only architecturally meaningful for the compare-style opcodes
  assign w_gold     = alu32_golden(r_alu_a, r_alu_b, r_alu_op);
  assign w_check_eq = (r_alu_op == OP_SUB) || (r_alu_op == OP_SLT);
  assign w_mismatch = (alu_S != w_gold.s) || (alu_overflow != w_gold.overflow) ||
                      (w_check_eq && (alu_eq != w_gold.eq));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_index      <= 8'd0;
      r_settle     <= 4'd0;
      r_lfsr       <= LFSR_SEED;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_index <= 8'd0;
      r_fail_s     <= 32'h0;
      r_alu_a      <= 32'h0;
      r_alu_b      <= 32'h0;
      r_alu_op     <= 5'd0;
`ifdef ALU32_BIST_ERRCOUNT_EN
      r_err_count  <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state      <= ST_DRIVE;
            r_index      <= 8'd0;
            r_lfsr       <= LFSR_SEED;
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
            r_fail_index <= 8'd0;
            r_fail_s     <= 32'h0;
`ifdef ALU32_BIST_ERRCOUNT_EN
            r_err_count  <= 8'd0;
`endif
          end
        end
        ST_DRIVE: begin
          if (r_index < NUM_DIRECTED) begin
            r_alu_a  <= w_rom_a;
            r_alu_b  <= w_rom_b;
            r_alu_op <= w_rom_op;
          end else begin
            r_alu_a  <= w_step1;
            r_alu_b  <= w_step2;
            r_alu_op <= w_rand_op;
            r_lfsr   <= w_step2;
          end
          r_settle <= 4'd0;
          r_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle == SETTLE_END) r_state <= ST_CHECK;
          else                        r_settle <= r_settle + 4'd1;
        end
        ST_CHECK: begin
`ifdef ALU32_BIST_ERRCOUNT_EN
          // First mismatch is the one seen while the count is still zero
          if (w_mismatch) begin
            if (r_err_count == 8'd0) begin
              r_fail_index <= r_index;
              r_fail_s     <= alu_S;
            end
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          end
          if (r_index == LAST_IDX) begin
            r_pass  <= (r_err_count == 8'd0) && !w_mismatch;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_index <= r_index + 8'd1;
            r_state <= ST_DRIVE;
          end
`else
          if (w_mismatch) begin
            r_fail_index <= r_index;
            r_fail_s     <= alu_S;
            r_pass       <= 1'b0;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_DONE;
          end else if (r_index == LAST_IDX) begin
            r_pass  <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_index <= r_index + 8'd1;
            r_state <= ST_DRIVE;
          end
`endif
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_index = r_fail_index;
  assign fail_S     = r_fail_s;
  assign alu_A      = r_alu_a;
  assign alu_B      = r_alu_b;
  assign alu_op     = r_alu_op;
`ifdef ALU32_BIST_ERRCOUNT_EN
  assign err_count  = r_err_count;
`endif

endmodule
